// File: rtl/sudoku_board_checker.sv
// sudoku_board_checker
//   Serial validity checker for a 9x9 sudoku board. The board is snapshotted
//   when a check is accepted. The checker then examines one cell per clock,
//   walking all rows, then all columns, then all 3x3 boxes. It reports the
//   first rule violation found, the number of empty cells, and whether the
//   board is solved.
// Ports:
//   clock_i          rising-edge clock
//   reset_n_i        synchronous active-low reset
//   start_i          request a check (accepted only when idle)
//   game_board_i     [row][col] 4-bit digits: 0 empty, 1..9 digit, 10..15 invalid
//   busy_o           high while scanning
//   done_o           one-cycle pulse when results are valid
//   conflict_o       rule violation found
//   conflict_kind_o  0 invalid digit, 1 row, 2 column, 3 box
//   conflict_row_o   row of the offending cell
//   conflict_col_o   column of the offending cell
//   empty_count_o    number of empty cells (counted during the row pass)
//   solved_o         no conflict and no empty cells
module sudoku_board_checker (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  start_i,
   input  logic [8:0][8:0][3:0]  game_board_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  conflict_o,
   output logic [1:0]            conflict_kind_o,
   output logic [3:0]            conflict_row_o,
   output logic [3:0]            conflict_col_o,
   output logic [6:0]            empty_count_o,
   output logic                  solved_o
);

   typedef enum logic [2:0] {StIdle, StRows, StCols, StBoxes, StDone} state_e;

   state_e               state_q, state_d;
   logic [3:0]           g_q, g_d, i_q, i_d;
   logic [8:0]           seen_q, seen_d;
   logic [6:0]           empty_q, empty_d;
   logic                 conflict_q, conflict_d;
   logic [1:0]           kind_q, kind_d;
   logic [3:0]           crow_q, crow_d, ccol_q, ccol_d;
   logic                 solved_q, solved_d;
   logic [8:0][8:0][3:0] board_q;
   logic                 load;

   logic [3:0] cell_r, cell_c, cell_v, v_idx;
   logic       abort;

   // Integer divide by 3 for values 0..8.
   function automatic logic [3:0] div3(input logic [3:0] x);
      if (x < 4'd3)      return 4'd0;
      else if (x < 4'd6) return 4'd1;
      else               return 4'd2;
   endfunction

   // Cell address for the current phase.
   always_comb begin
      cell_r = g_q;
      cell_c = i_q;
      unique case (state_q)
         StCols: begin
            cell_r = i_q;
            cell_c = g_q;
         end
         StBoxes: begin
            cell_r = 4'd3 * div3(g_q) + div3(i_q);
            cell_c = 4'd3 * (g_q - 4'd3 * div3(g_q)) + (i_q - 4'd3 * div3(i_q));
         end
         default: ;
      endcase
   end

   assign cell_v = board_q[cell_r][cell_c];
   assign v_idx  = cell_v - 4'd1;

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      i_d        = i_q;
      seen_d     = seen_q;
      empty_d    = empty_q;
      conflict_d = conflict_q;
      kind_d     = kind_q;
      crow_d     = crow_q;
      ccol_d     = ccol_q;
      solved_d   = solved_q;
      load       = 1'b0;
      abort      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               load       = 1'b1;
               g_d        = 4'd0;
               i_d        = 4'd0;
               seen_d     = '0;
               empty_d    = '0;
               conflict_d = 1'b0;
               kind_d     = 2'd0;
               crow_d     = 4'd0;
               ccol_d     = 4'd0;
               solved_d   = 1'b0;
               state_d    = StRows;
            end
         end
         StRows, StCols, StBoxes: begin
            if (cell_v == 4'd0) begin
               if (state_q == StRows) empty_d = empty_q + 7'd1;
            end else if (cell_v > 4'd9) begin
               // Out-of-range digits are caught in the row pass; later passes
               // never see one because the scan has already aborted.
               if (state_q == StRows) begin
                  abort  = 1'b1;
                  kind_d = 2'd0;
               end
            end else if (seen_q[v_idx]) begin
               abort  = 1'b1;
               kind_d = (state_q == StRows) ? 2'd1 : (state_q == StCols) ? 2'd2 : 2'd3;
            end else begin
               seen_d[v_idx] = 1'b1;
            end

            if (abort) begin
               conflict_d = 1'b1;
               crow_d     = cell_r;
               ccol_d     = cell_c;
               state_d    = StDone;
            end else if (i_q == 4'd8) begin
               i_d    = 4'd0;
               seen_d = '0;
               g_d    = g_q + 4'd1;
               if (g_q == 4'd8) begin
                  g_d = 4'd0;
                  unique case (state_q)
                     StRows:  state_d = StCols;
                     StCols:  state_d = StBoxes;
                     default: state_d = StDone;
                  endcase
               end
            end else begin
               i_d = i_q + 4'd1;
            end

            if (state_d == StDone) solved_d = !conflict_d && (empty_d == 7'd0);
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q    <= StIdle;
         g_q        <= 4'd0;
         i_q        <= 4'd0;
         seen_q     <= '0;
         empty_q    <= '0;
         conflict_q <= 1'b0;
         kind_q     <= 2'd0;
         crow_q     <= 4'd0;
         ccol_q     <= 4'd0;
         solved_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         i_q        <= i_d;
         seen_q     <= seen_d;
         empty_q    <= empty_d;
         conflict_q <= conflict_d;
         kind_q     <= kind_d;
         crow_q     <= crow_d;
         ccol_q     <= ccol_d;
         solved_q   <= solved_d;
      end
   end

   // Snapshot has no reset: its contents are irrelevant until a start loads it.
   always_ff @(posedge clock_i) begin
      if (load) board_q <= game_board_i;
   end

   assign busy_o          = (state_q == StRows) || (state_q == StCols) || (state_q == StBoxes);
   assign done_o          = (state_q == StDone);
   assign conflict_o      = conflict_q;
   assign conflict_kind_o = kind_q;
   assign conflict_row_o  = crow_q;
   assign conflict_col_o  = ccol_q;
   assign empty_count_o   = empty_q;
   assign solved_o        = solved_q;

endmodule

// File: doc/sudoku_board_checker.md
# sudoku_board_checker

Scans the 9x9 game board produced by the board selection stage and reports whether it is valid, complete, and where the first rule violation lies. It sits directly downstream of board selection, consuming `game_board`. It feeds the win/error indication logic. One cell is examined per clock, so there is no 81-way comparator tree. The board is snapshotted on `start`, so edits during a scan do not affect the result.

## Interface
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  request a check; honoured only in IDLE
- `game_board`  in  [3:0] [8:0][8:0]  board digits; 0 = empty, 1..9 = digit, 10..15 = invalid
- `busy`  out  1  high while scanning
- `done`  out  1  one-cycle pulse when results become valid
- `conflict`  out  1  rule violation found
- `conflict_kind`  out  2  0 invalid digit, 1 row, 2 column, 3 box; meaningful only when `conflict`=1
- `conflict_row`, `conflict_col`  out  4 each  cell where the violation was detected (0..8)
- `empty_count`  out  7  number of 0 cells (0..81)
- `solved`  out  1  `conflict`=0 and `empty_count`=0

## Operation
- States: IDLE, ROWS, COLS, BOXES, DONE. Counters: group `g` (0..8) and index `i` (0..8). A 9-bit `seen` mask is cleared at every group start.
- IDLE with `start`=1:
  - copy `game_board` into the snapshot
  - clear `seen`, `g`, `i`, the running empty count, and the conflict registers
  - go to ROWS
- Cell addressing:
  - ROWS: (r,c) = (g,i)
  - COLS: (r,c) = (i,g)
  - BOXES: r = 3*(g/3)+i/3, c = 3*(g%3)+i%3
- Per examined cell value v:
  - v=0: skip. In ROWS only, increment the empty count.
  - v>9: checked in ROWS only. Latch conflict kind 0 at (r,c), go to DONE.
  - `seen[v-1]`=1: latch conflict with kind = current phase at (r,c), go to DONE.
  - otherwise: set `seen[v-1]`.
- Advance:
  - i=8: i←0, clear `seen`, g←g+1.
  - g=8 and i=8: g←0 and move ROWS→COLS→BOXES→DONE.
- DONE:
  - lasts one cycle; register all results, pulse `done`, return to IDLE
  - results hold until the next accepted `start`
- On conflict abort, `empty_count` reports the cells counted so far. `solved` is forced to 0.
- `start` while not in IDLE is ignored. A `start` in the DONE cycle is ignored.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE; all outputs 0; snapshot contents don't-care.
- Reset mid-scan: IDLE on the next edge, no `done` pulse, results cleared to 0.
- `start` sampled at edge t:
  - snapshot taken at t
  - first cell examined in cycle t+1
  - `busy` is high from t+1 through the last examined cycle
- Clean scan:
  - ROWS occupies t+1..t+81, COLS t+82..t+162, BOXES t+163..t+243
  - `done` is high, with results visible, at t+244; `busy` is low in that cycle
- Conflict detected while examining cycle c: `done` and results at c+1, and `busy` is low at c+1.
- Earliest `start` that is accepted: the cycle after `done`.

## Test plan
- Valid fully-solved grid, `start` at t → `done` at t+244; `solved`=1, `conflict`=0, `empty_count`=0; `busy` high for exactly 243 cycles.
- All-zero board → `done` at t+244; `empty_count`=81, `conflict`=0, `solved`=0.
- Zeros except (0,0)=5 and (0,4)=5 → `done` at t+6; `conflict`=1, kind 1, row 0, col 4, `empty_count`=3.
- Zeros except (0,0)=5 and (3,0)=5 → `done` at t+86; kind 2, row 3, col 0. Same board with (1,1) instead of (3,0) → `done` at t+168; kind 3, row 1, col 1.
- Zeros except (2,3)=12 → `done` at t+23; kind 0, row 2, col 3. Changing `game_board` mid-scan of a valid board does not change the result.
- `start` pulsed at t+50 is ignored. `reset_n` low at t+100 → IDLE at t+101, outputs 0, no `done`. A new `start` then completes normally.
